// File: rtl/tcam_prio_if.sv
// Bundles the search, result and rule-set signals of tcam_prio.
// The master drives the requests and the slave (the TCAM) returns results.
interface tcam_prio_if #(
  parameter int KWID  = 104,
  parameter int IDWID = 8,
  parameter int PRIOR = 8,
  parameter int AWID  = 4
);
  localparam int MASKWID  = KWID / 8;
  localparam int TOTALWID = KWID + MASKWID + PRIOR;

  // Neither channel can be back-pressured. A search is accepted on every edge where
  // i_Key_Valid=1. A set/delete is accepted on every edge where i_Set_Enable=1.
  // o_Valid qualifies o_Hit/o_Multi/o_RuleID. o_Set_Done acks each set or delete.
  logic [KWID-1:0]     i_Key;
  logic                i_Key_Valid;
  logic                o_Valid;
  logic                o_Hit;
  logic                o_Multi;
  logic [IDWID-1:0]    o_RuleID;
  logic                i_Set_Enable;
  logic                i_Set_Del;
  logic [AWID-1:0]     i_Set_Addr;
  logic [TOTALWID-1:0] i_Set_String;
  logic [IDWID-1:0]    i_Set_ID;
  logic                o_Set_Done;

  modport master (
    output i_Key, i_Key_Valid, i_Set_Enable, i_Set_Del, i_Set_Addr, i_Set_String, i_Set_ID,
    input  o_Valid, o_Hit, o_Multi, o_RuleID, o_Set_Done
  );

  modport slave (
    input  i_Key, i_Key_Valid, i_Set_Enable, i_Set_Del, i_Set_Addr, i_Set_String, i_Set_ID,
    output o_Valid, o_Hit, o_Multi, o_RuleID, o_Set_Done
  );
endinterface

// File: rtl/tcam_prio.sv
// Register-based ternary CAM with per-byte wildcards and priority resolution.
// Stage 1 registers the match vector plus a rule snapshot. Stage 2 picks the winner.
module tcam_prio #(
  parameter int KWID     = 104,
  parameter int MASKWID  = KWID / 8,
  parameter int IDWID    = 8,
  parameter int PRIOR    = 8,
  parameter int AWID     = 4,
  parameter int DEP      = 1 << AWID,
  parameter int TOTALWID = KWID + MASKWID + PRIOR
) (
  input logic        clk,
  input logic        rst,
  tcam_prio_if.slave bus
);

  logic [KWID-1:0]    r_key   [DEP];
  logic [MASKWID-1:0] r_mask  [DEP];
  logic [PRIOR-1:0]   r_prio  [DEP];
  logic [IDWID-1:0]   r_id    [DEP];
  logic [DEP-1:0]     r_valid;

  logic               r_s1_valid;
  logic [DEP-1:0]     r_s1_match;
  logic [PRIOR-1:0]   r_s1_prio [DEP];
  logic [IDWID-1:0]   r_s1_id   [DEP];

  logic               r_o_valid;
  logic               r_o_hit;
  logic               r_o_multi;
  logic [IDWID-1:0]   r_o_id;
  logic               r_set_done;

  logic [DEP-1:0]     w_match;
  logic               w_found;
  logic               w_multi;
  logic [PRIOR-1:0]   w_best_prio;
  logic [IDWID-1:0]   w_best_id;
  logic               w_write;

  assign w_write = bus.i_Set_Enable && !bus.i_Set_Del;

  // Rule contents need no reset; only the slot valid bits gate matching.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_key[bus.i_Set_Addr]  <= bus.i_Set_String[KWID-1:0];
      r_mask[bus.i_Set_Addr] <= bus.i_Set_String[KWID +: MASKWID];
      r_prio[bus.i_Set_Addr] <= bus.i_Set_String[TOTALWID-1 -: PRIOR];
      r_id[bus.i_Set_Addr]   <= bus.i_Set_ID;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= '0;
      r_set_done <= 1'b0;
    end else begin
      r_set_done <= bus.i_Set_Enable;
      if (bus.i_Set_Enable) r_valid[bus.i_Set_Addr] <= !bus.i_Set_Del;
    end
  end

  // Matching reads the pre-edge table, so a search sharing an edge with a set sees the old rule.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEP; i++) begin
      w_match[i] = r_valid[i];
      for (int b = 0; b < MASKWID; b++) begin
        if (!r_mask[i][b] && (r_key[i][8*b +: 8] != bus.i_Key[8*b +: 8])) w_match[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.i_Key_Valid) begin
      r_s1_prio <= r_prio;
      r_s1_id   <= r_id;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_match <= '0;
    end else begin
      r_s1_valid <= bus.i_Key_Valid;
      if (bus.i_Key_Valid) r_s1_match <= w_match;
    end
  end

  // Strict greater-than keeps the earliest (lowest-index) slot on a priority tie.
  always_comb begin
    w_found     = 1'b0;
    w_multi     = 1'b0;
    w_best_prio = '0;
    w_best_id   = '0;
    for (int i = 0; i < DEP; i++) begin
      if (r_s1_match[i]) begin
        if (w_found) w_multi = 1'b1;
        if (!w_found || (r_s1_prio[i] > w_best_prio)) begin
          w_best_prio = r_s1_prio[i];
          w_best_id   = r_s1_id[i];
        end
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_o_valid <= 1'b0;
      r_o_hit   <= 1'b0;
      r_o_multi <= 1'b0;
      r_o_id    <= '0;
    end else if (r_s1_valid) begin
      r_o_valid <= 1'b1;
      r_o_hit   <= w_found;
      r_o_multi <= w_multi;
      r_o_id    <= w_best_id;
    end else begin
      r_o_valid <= 1'b0;
      r_o_hit   <= 1'b0;
      r_o_multi <= 1'b0;
      r_o_id    <= '0;
    end
  end

  assign bus.o_Valid    = r_o_valid;
  assign bus.o_Hit      = r_o_hit;
  assign bus.o_Multi    = r_o_multi;
  assign bus.o_RuleID   = r_o_id;
  assign bus.o_Set_Done = r_set_done;

endmodule

// File: tb/tb_tcam_prio.sv
// Directed bench for tcam_prio: lookups, wildcards, priority ties, set/search hazard,
// back-to-back streaming and reset while searches are in flight.
module tb_tcam_prio;

  localparam int KWID     = 104;
  localparam int MASKWID  = 13;
  localparam int IDWID    = 8;
  localparam int PRIOR    = 8;
  localparam int AWID     = 4;
  localparam int TOTALWID = KWID + MASKWID + PRIOR;

  localparam logic [KWID-1:0] KEY0 = 104'h40_5B_6A_00_A4_68_00_00_FF_FF_FF_FF_FF;
  localparam logic [KWID-1:0] KEYK = 104'hC0_97_0B_36_00_00_00_00_FF_FF_FF_FF_FF;
  localparam logic [MASKWID-1:0] MASK0 = 13'b0001001100000;
  localparam logic [MASKWID-1:0] MASK2 = 13'b0000011100000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  tcam_prio_if #(.KWID(KWID), .IDWID(IDWID), .PRIOR(PRIOR), .AWID(AWID)) bus ();

  tcam_prio #(.KWID(KWID), .IDWID(IDWID), .PRIOR(PRIOR), .AWID(AWID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result packed as {valid, hit, multi, id}
  logic [10:0] res;
  assign res = {bus.o_Valid, bus.o_Hit, bus.o_Multi, bus.o_RuleID};

  // ---- driver tasks ----
  task automatic drive_idle();
    bus.i_Key        = '0;
    bus.i_Key_Valid  = 1'b0;
    bus.i_Set_Enable = 1'b0;
    bus.i_Set_Del    = 1'b0;
    bus.i_Set_Addr   = '0;
    bus.i_Set_String = '0;
    bus.i_Set_ID     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_search(input logic [KWID-1:0] key);
    bus.i_Key       = key;
    bus.i_Key_Valid = 1'b1;
    tick();
    bus.i_Key_Valid = 1'b0;
  endtask

  task automatic drive_set(input logic [AWID-1:0] addr, input logic [PRIOR-1:0] prio,
                           input logic [MASKWID-1:0] mask, input logic [KWID-1:0] key,
                           input logic [IDWID-1:0] id);
    bus.i_Set_Enable = 1'b1;
    bus.i_Set_Del    = 1'b0;
    bus.i_Set_Addr   = addr;
    bus.i_Set_String = {prio, mask, key};
    bus.i_Set_ID     = id;
    tick();
    bus.i_Set_Enable = 1'b0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    #3;
    n_checks++;
    if ({res, bus.o_Set_Done} !== 12'h000)
      $display("FAIL reset_outputs: got %h want 000", {res, bus.o_Set_Done});
    else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    drive_search(KEY0);
    n_checks++;
    if (res !== 11'h000) $display("FAIL empty_latency1: got %h want 000", res);
    else n_pass++;
    tick();
    n_checks++;
    if (res !== 11'h400) $display("FAIL empty_miss: got %h want 400", res);
    else n_pass++;
    tick();
    n_checks++;
    if (res !== 11'h000) $display("FAIL empty_idle: got %h want 000", res);
    else n_pass++;
  endtask

  task automatic test_wildcard();
    drive_set(4'd0, 8'h00, MASK0, KEY0, 8'h00);
    n_checks++;
    if (bus.o_Set_Done !== 1'b1) $display("FAIL set_done_pulse: got %b want 1", bus.o_Set_Done);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.o_Set_Done !== 1'b0) $display("FAIL set_done_single: got %b want 0", bus.o_Set_Done);
    else n_pass++;
    drive_search(104'h40_5B_6A_00_A4_68_00_77_FF_FF_FF_FF_FF);
    tick();
    n_checks++;
    if (res !== 11'h600) $display("FAIL wildcard_byte5: got %h want 600", res);
    else n_pass++;
    drive_search(104'h40_5B_6A_00_A4_68_00_00_FF_FF_FF_FF_FE);
    tick();
    n_checks++;
    if (res !== 11'h400) $display("FAIL exact_byte0_miss: got %h want 400", res);
    else n_pass++;
  endtask

  task automatic test_priority();
    drive_set(4'd1, 8'h10, 13'b0, KEYK, 8'h08);
    n_checks++;
    if (bus.o_Set_Done !== 1'b1) $display("FAIL b2b_done_1: got %b want 1", bus.o_Set_Done);
    else n_pass++;
    drive_set(4'd2, 8'h20, MASK2, KEYK, 8'h03);
    n_checks++;
    if (bus.o_Set_Done !== 1'b1) $display("FAIL b2b_done_2: got %b want 1", bus.o_Set_Done);
    else n_pass++;
    drive_search(KEYK);
    n_checks++;
    if (bus.o_Set_Done !== 1'b0) $display("FAIL b2b_done_end: got %b want 0", bus.o_Set_Done);
    else n_pass++;
    tick();
    n_checks++;
    if (res !== 11'h703) $display("FAIL prio_high_wins: got %h want 703", res);
    else n_pass++;
    drive_set(4'd2, 8'h10, MASK2, KEYK, 8'h03);
    drive_search(KEYK);
    tick();
    n_checks++;
    if (res !== 11'h708) $display("FAIL prio_tie_low_index: got %h want 708", res);
    else n_pass++;
    drive_set(4'd2, 8'h20, MASK2, KEYK, 8'h03);
  endtask

  task automatic test_hazard();
    bus.i_Set_Enable = 1'b1;
    bus.i_Set_Del    = 1'b1;
    bus.i_Set_Addr   = 4'd2;
    bus.i_Set_String = '1;
    bus.i_Key        = KEYK;
    bus.i_Key_Valid  = 1'b1;
    tick();
    bus.i_Set_Enable = 1'b0;
    bus.i_Set_Del    = 1'b0;
    n_checks++;
    if (bus.o_Set_Done !== 1'b1) $display("FAIL del_done: got %b want 1", bus.o_Set_Done);
    else n_pass++;
    tick();
    bus.i_Key_Valid = 1'b0;
    n_checks++;
    if (res !== 11'h703) $display("FAIL hazard_old_state: got %h want 703", res);
    else n_pass++;
    tick();
    n_checks++;
    if (res !== 11'h608) $display("FAIL hazard_new_state: got %h want 608", res);
    else n_pass++;
    // Delete request without enable must not touch slot 1
    bus.i_Set_Del  = 1'b1;
    bus.i_Set_Addr = 4'd1;
    drive_search(KEYK);
    bus.i_Set_Del = 1'b0;
    tick();
    n_checks++;
    if (res !== 11'h608) $display("FAIL del_without_enable: got %h want 608", res);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [KWID-1:0] keys [11];
    logic [10:0]     exp  [11];
    int              n_valid;
    keys[0]  = KEYK;                                          exp[0]  = 11'h608;
    keys[1]  = KEY0;                                          exp[1]  = 11'h600;
    keys[2]  = 104'h40_5B_6A_00_A4_68_00_77_FF_FF_FF_FF_FF;   exp[2]  = 11'h600;
    keys[3]  = 104'h40_5B_6A_00_A4_68_12_00_FF_FF_FF_FF_FF;   exp[3]  = 11'h600;
    keys[4]  = 104'h40_5B_6A_99_A4_68_00_00_FF_FF_FF_FF_FF;   exp[4]  = 11'h600;
    keys[5]  = 104'h40_5B_6A_00_A4_68_00_00_00_FF_FF_FF_FF;   exp[5]  = 11'h400;
    keys[6]  = 104'hC0_97_0B_36_00_00_00_01_FF_FF_FF_FF_FF;   exp[6]  = 11'h400;
    keys[7]  = '0;                                            exp[7]  = 11'h400;
    keys[8]  = KEYK;                                          exp[8]  = 11'h608;
    keys[9]  = 104'h41_5B_6A_00_A4_68_00_00_FF_FF_FF_FF_FF;   exp[9]  = 11'h400;
    keys[10] = KEY0;                                          exp[10] = 11'h600;
    n_valid = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 11) begin
        bus.i_Key       = keys[c];
        bus.i_Key_Valid = 1'b1;
      end else begin
        bus.i_Key_Valid = 1'b0;
      end
      tick();
      if (bus.o_Valid === 1'b1) n_valid++;
      if (c == 0) begin
        n_checks++;
        if (res !== 11'h000) $display("FAIL b2b_first_latency: got %h want 000", res);
        else n_pass++;
      end else begin
        n_checks++;
        if (res !== exp[c-1]) $display("FAIL b2b_result_%0d: got %h want %h", c - 1, res, exp[c-1]);
        else n_pass++;
      end
    end
    tick();
    n_checks++;
    if (n_valid !== 11 || res !== 11'h000)
      $display("FAIL b2b_valid_count: got %0d (tail %h) want 11 (tail 000)", n_valid, res);
    else n_pass++;
  endtask

  task automatic test_boundary();
    drive_set(4'd15, 8'hFF, 13'h1FFF, '0, 8'hF0);
    drive_search(KEYK);
    tick();
    n_checks++;
    if (res !== 11'h7F0) $display("FAIL top_slot_max_prio: got %h want 7F0", res);
    else n_pass++;
    drive_search(104'h12_34_56_78_9A_BC_DE_F0_11_22_33_44_55);
    tick();
    n_checks++;
    if (res !== 11'h6F0) $display("FAIL full_wildcard: got %h want 6F0", res);
    else n_pass++;
  endtask

  task automatic test_reset_inflight();
    bus.i_Key       = KEYK;
    bus.i_Key_Valid = 1'b1;
    tick();
    bus.i_Key = KEY0;
    tick();
    bus.i_Key_Valid = 1'b0;
    n_checks++;
    if (res !== 11'h7F0) $display("FAIL inflight_first: got %h want 7F0", res);
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (res !== 11'h000) $display("FAIL reset_immediate: got %h want 000", res);
    else n_pass++;
    tick();
    #2;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (res !== 11'h000) $display("FAIL no_stale_valid_%0d: got %h want 000", c, res);
      else n_pass++;
    end
    drive_search(KEYK);
    tick();
    n_checks++;
    if (res !== 11'h400) $display("FAIL post_reset_miss_k: got %h want 400", res);
    else n_pass++;
    drive_search(KEY0);
    tick();
    n_checks++;
    if (res !== 11'h400) $display("FAIL post_reset_miss_0: got %h want 400", res);
    else n_pass++;
  endtask

  // ---- sequence and report ----
  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_wildcard();
    test_priority();
    test_hazard();
    test_back_to_back();
    test_boundary();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
